// File: rtl/scurve_single_point_test.sv
// Runs a single S-curve point: fires Pulse_Num CTest injections, counts the
// injections that raise a trigger inside the window, then writes a 3-word record.
module scurve_single_point_test #(
  parameter int unsigned PULSE_PERIOD = 400,
  parameter int unsigned PULSE_WIDTH  = 4,
  parameter int unsigned WINDOW       = 40
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        Single_Test_Start,
  input  logic [9:0]  Dac_Code,
  input  logic [15:0] Pulse_Num,
  input  logic        Trigger_In,
  output logic        CTest_Pulse,
  input  logic        SCurve_Data_fifo_full,
  output logic        SCurve_Data_fifo_wr_en,
  output logic [15:0] SCurve_Data_fifo_dout,
  output logic        Single_Test_Done,
  output logic        Busy
);

  localparam int unsigned PCW = $clog2(PULSE_PERIOD);

  typedef enum logic [2:0] {
    IDLE, PULSE, GAP, WR_HDR, WR_CNT, WR_HIT, DONE
  } state_t;

  state_t          state_q;
  logic [9:0]      dac_q;
  logic [15:0]     num_q;
  logic [15:0]     pulse_cnt_q;
  logic [15:0]     hit_cnt_q;
  logic [15:0]     hit_cnt_d;
  logic [PCW-1:0]  period_cnt_q;
  logic            hit_flag_q;
  logic [2:0]      trig_sync_q;
  logic            trig_edge_q;
  logic            ctest_q;
  logic            wr_en_q;
  logic [15:0]     dout_q;
  logic            done_q;
  logic            busy_q;

  logic            in_window;
  logic            hit_take;
  logic            last_pulse;
  logic [15:0]     hdr_word;

  // Two-stage synchroniser plus registered rising-edge detect: 3 cycles pin to edge.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_sync_q <= '0;
      trig_edge_q <= 1'b0;
    end else begin
      trig_sync_q <= {trig_sync_q[1:0], Trigger_In};
      trig_edge_q <= trig_sync_q[1] & ~trig_sync_q[2];
    end
  end

  always_comb begin
    in_window  = (period_cnt_q != '0) && (period_cnt_q <= PCW'(WINDOW + 3));
    hit_take   = trig_edge_q && in_window && !hit_flag_q &&
                 ((state_q == PULSE) || (state_q == GAP));
    hit_cnt_d  = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
    last_pulse = ((pulse_cnt_q + 16'd1) == num_q);
    hdr_word   = {6'b100000, dac_q};
  end

  // Each write state names the word on the FIFO bus: the strobe for a word is
  // registered on the edge entering (or retrying) its state, so the state
  // advances once the strobe has been seen high for one cycle.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      dac_q        <= '0;
      num_q        <= '0;
      pulse_cnt_q  <= '0;
      hit_cnt_q    <= '0;
      period_cnt_q <= '0;
      hit_flag_q   <= 1'b0;
      ctest_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      dout_q       <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;

      if (hit_take) begin
        hit_cnt_q  <= hit_cnt_d;
        hit_flag_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (Single_Test_Start) begin
            dac_q       <= Dac_Code;
            num_q       <= Pulse_Num;
            pulse_cnt_q <= '0;
            hit_cnt_q   <= '0;
            busy_q      <= 1'b1;
            if (Pulse_Num != 16'd0) begin
              state_q      <= PULSE;
              ctest_q      <= 1'b1;
              period_cnt_q <= '0;
            end else begin
              state_q <= WR_HDR;
              if (!SCurve_Data_fifo_full) begin
                wr_en_q <= 1'b1;
                dout_q  <= {6'b100000, Dac_Code};
              end
            end
          end
        end

        PULSE: begin
          if (period_cnt_q == '0) hit_flag_q <= 1'b0;
          period_cnt_q <= period_cnt_q + 1'b1;
          if (period_cnt_q == PCW'(PULSE_WIDTH - 1)) begin
            ctest_q <= 1'b0;
            state_q <= GAP;
          end
        end

        GAP: begin
          if (period_cnt_q == PCW'(PULSE_PERIOD - 1)) begin
            pulse_cnt_q  <= pulse_cnt_q + 16'd1;
            period_cnt_q <= '0;
            if (last_pulse) begin
              state_q <= WR_HDR;
              if (!SCurve_Data_fifo_full) begin
                wr_en_q <= 1'b1;
                dout_q  <= hdr_word;
              end
            end else begin
              state_q <= PULSE;
              ctest_q <= 1'b1;
            end
          end else begin
            period_cnt_q <= period_cnt_q + 1'b1;
          end
        end

        WR_HDR: begin
          if (wr_en_q) begin
            state_q <= WR_CNT;
            if (!SCurve_Data_fifo_full) begin
              wr_en_q <= 1'b1;
              dout_q  <= pulse_cnt_q;
            end
          end else if (!SCurve_Data_fifo_full) begin
            wr_en_q <= 1'b1;
            dout_q  <= hdr_word;
          end
        end

        WR_CNT: begin
          if (wr_en_q) begin
            state_q <= WR_HIT;
            if (!SCurve_Data_fifo_full) begin
              wr_en_q <= 1'b1;
              dout_q  <= hit_cnt_q;
            end
          end else if (!SCurve_Data_fifo_full) begin
            wr_en_q <= 1'b1;
            dout_q  <= pulse_cnt_q;
          end
        end

        WR_HIT: begin
          if (wr_en_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (!SCurve_Data_fifo_full) begin
            wr_en_q <= 1'b1;
            dout_q  <= hit_cnt_q;
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign CTest_Pulse            = ctest_q;
  assign SCurve_Data_fifo_wr_en = wr_en_q;
  assign SCurve_Data_fifo_dout  = dout_q;
  assign Single_Test_Done       = done_q;
  assign Busy                   = busy_q;

endmodule

// File: tb/tb_scurve_single_point_test.sv
// Directed bench for scurve_single_point_test: records, trigger windows,
// FIFO back-pressure, ignored start, mid-test reset and zero-injection points.
module tb_scurve_single_point_test;

  logic        Clk = 1'b0;
  logic        reset_n;
  logic        Single_Test_Start;
  logic [9:0]  Dac_Code;
  logic [15:0] Pulse_Num;
  logic        Trigger_In;
  logic        CTest_Pulse;
  logic        SCurve_Data_fifo_full;
  logic        SCurve_Data_fifo_wr_en;
  logic [15:0] SCurve_Data_fifo_dout;
  logic        Single_Test_Done;
  logic        Busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] fifo_q[$];
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int last_wr_cyc = 0;
  int done_cnt = 0;
  int ctest_rises = 0;
  logic ctest_prev = 1'b0;

  int trig_mode = 0;
  int trig_dly  = 5;

  scurve_single_point_test #(
    .PULSE_PERIOD(400),
    .PULSE_WIDTH (4),
    .WINDOW      (40)
  ) dut (
    .Clk                   (Clk),
    .reset_n               (reset_n),
    .Single_Test_Start     (Single_Test_Start),
    .Dac_Code              (Dac_Code),
    .Pulse_Num             (Pulse_Num),
    .Trigger_In            (Trigger_In),
    .CTest_Pulse           (CTest_Pulse),
    .SCurve_Data_fifo_full (SCurve_Data_fifo_full),
    .SCurve_Data_fifo_wr_en(SCurve_Data_fifo_wr_en),
    .SCurve_Data_fifo_dout (SCurve_Data_fifo_dout),
    .Single_Test_Done      (Single_Test_Done),
    .Busy                  (Busy)
  );

  always #12.5 Clk = ~Clk;

  // FIFO and event monitor; cyc identifies the cycle that ends at this edge.
  always @(posedge Clk) begin
    if (SCurve_Data_fifo_wr_en) begin
      fifo_q.push_back(SCurve_Data_fifo_dout);
      last_wr_cyc = cyc;
    end
    if (Single_Test_Start && !Busy && reset_n) start_cyc = cyc;
    if (Single_Test_Done) begin
      done_cyc = cyc;
      done_cnt++;
    end
    if (CTest_Pulse && !ctest_prev) ctest_rises++;
    ctest_prev = CTest_Pulse;
    cyc++;
  end

  // Trigger generator, referenced to each CTest rising edge.
  initial begin
    Trigger_In = 1'b0;
    forever begin
      @(posedge CTest_Pulse);
      if (trig_mode == 1) begin
        repeat (trig_dly) @(posedge Clk);
        #1 Trigger_In = 1'b1;
        repeat (3) @(posedge Clk);
        #1 Trigger_In = 1'b0;
      end else if (trig_mode == 2) begin
        for (int k = 0; k < 3; k++) begin
          repeat (5) @(posedge Clk);
          #1 Trigger_In = 1'b1;
          repeat (2) @(posedge Clk);
          #1 Trigger_In = 1'b0;
        end
      end
    end
  end

  function automatic logic [15:0] word_at(input int i);
    return (fifo_q.size() > i) ? fifo_q[i] : 16'hDEAD;
  endfunction

  task automatic clear_obs();
    fifo_q.delete();
    ctest_rises = 0;
  endtask

  // Caller is at a negedge; Start is high for exactly the following cycle.
  task automatic start_test(input logic [9:0] dac, input logic [15:0] num);
    Dac_Code          = dac;
    Pulse_Num         = num;
    Single_Test_Start = 1'b1;
    @(negedge Clk);
    Single_Test_Start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge Clk);
      if (Single_Test_Done) begin
        found = 1;
        if (Busy !== 1'b1) begin
          $display("FAIL %s busy_at_done got=%b exp=1", name, Busy); bad++;
        end
        total++;
        @(negedge Clk);
        if (Busy !== 1'b0 || Single_Test_Done !== 1'b0) begin
          $display("FAIL %s after_done busy=%b done=%b exp=0/0", name, Busy, Single_Test_Done); bad++;
        end
        total++;
      end
    end
    if (!found) begin
      $display("FAIL %s done_timeout got=none exp=pulse within %0d", name, budget); bad++;
    end
    total++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    Single_Test_Start = 1'b0; Dac_Code = '0; Pulse_Num = '0;
    SCurve_Data_fifo_full = 1'b0;
    repeat (3) @(negedge Clk);
    if ({CTest_Pulse, SCurve_Data_fifo_wr_en, Single_Test_Done, Busy} !== 4'b0000) begin
      $display("FAIL reset_ctrl got=%b exp=0000",
               {CTest_Pulse, SCurve_Data_fifo_wr_en, Single_Test_Done, Busy}); bad++;
    end
    total++;
    if (SCurve_Data_fifo_dout !== 16'h0000) begin
      $display("FAIL reset_dout got=%h exp=0000", SCurve_Data_fifo_dout); bad++;
    end
    total++;
    reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    if ({CTest_Pulse, SCurve_Data_fifo_wr_en, Busy} !== 3'b000) begin
      $display("FAIL idle_after_reset got=%b exp=000",
               {CTest_Pulse, SCurve_Data_fifo_wr_en, Busy}); bad++;
    end
    total++;
  endtask

  task automatic test_basic();
    clear_obs();
    trig_mode = 1; trig_dly = 5;
    start_test(10'h155, 16'd4);
    if (Busy !== 1'b1 || CTest_Pulse !== 1'b1) begin
      $display("FAIL basic_first_cycle busy=%b ctest=%b exp=1/1", Busy, CTest_Pulse); bad++;
    end
    total++;
    wait_done(1800, "basic");
    if (fifo_q.size() != 3 || word_at(0) !== 16'h8155 || word_at(1) !== 16'h0004 || word_at(2) !== 16'h0004) begin
      $display("FAIL basic_record got=%0d:%h,%h,%h exp=3:8155,0004,0004",
               fifo_q.size(), word_at(0), word_at(1), word_at(2)); bad++;
    end
    total++;
    if (done_cyc - start_cyc != 1604) begin
      $display("FAIL basic_latency got=%0d exp=1604", done_cyc - start_cyc); bad++;
    end
    total++;
    if (done_cyc - last_wr_cyc != 1) begin
      $display("FAIL basic_done_after_write got=%0d exp=1", done_cyc - last_wr_cyc); bad++;
    end
    total++;
    if (ctest_rises != 4) begin
      $display("FAIL basic_ctest_count got=%0d exp=4", ctest_rises); bad++;
    end
    total++;
    trig_mode = 0;
  endtask

  task automatic test_late_trigger();
    clear_obs();
    trig_mode = 1; trig_dly = 100;
    start_test(10'h0AA, 16'd3);
    wait_done(1400, "late");
    if (fifo_q.size() != 3 || word_at(0) !== 16'h80AA || word_at(1) !== 16'h0003 || word_at(2) !== 16'h0000) begin
      $display("FAIL late_record got=%0d:%h,%h,%h exp=3:80aa,0003,0000",
               fifo_q.size(), word_at(0), word_at(1), word_at(2)); bad++;
    end
    total++;
    trig_mode = 0;
  endtask

  task automatic test_multi_edge();
    clear_obs();
    trig_mode = 2;
    start_test(10'h200, 16'd2);
    wait_done(1000, "multi");
    if (fifo_q.size() != 3 || word_at(0) !== 16'h8200 || word_at(1) !== 16'h0002 || word_at(2) !== 16'h0002) begin
      $display("FAIL multi_record got=%0d:%h,%h,%h exp=3:8200,0002,0002",
               fifo_q.size(), word_at(0), word_at(1), word_at(2)); bad++;
    end
    total++;
    trig_mode = 0;
  endtask

  task automatic test_back_pressure();
    bit seen = 0;
    clear_obs();
    trig_mode = 1; trig_dly = 5;
    start_test(10'h001, 16'd1);
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge Clk);
      if (SCurve_Data_fifo_wr_en) seen = 1;
    end
    if (!seen) begin
      $display("FAIL bp_header_timeout got=none exp=header write"); bad++;
    end
    total++;
    SCurve_Data_fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (SCurve_Data_fifo_wr_en !== 1'b0 || SCurve_Data_fifo_dout !== 16'h8001) begin
        $display("FAIL bp_stall[%0d] wr_en=%b dout=%h exp=0/8001", i,
                 SCurve_Data_fifo_wr_en, SCurve_Data_fifo_dout); bad++;
      end
      total++;
    end
    SCurve_Data_fifo_full = 1'b0;
    @(negedge Clk);
    if (SCurve_Data_fifo_wr_en !== 1'b1 || SCurve_Data_fifo_dout !== 16'h0001) begin
      $display("FAIL bp_resume wr_en=%b dout=%h exp=1/0001",
               SCurve_Data_fifo_wr_en, SCurve_Data_fifo_dout); bad++;
    end
    total++;
    wait_done(20, "bp");
    if (fifo_q.size() != 3 || word_at(0) !== 16'h8001 || word_at(1) !== 16'h0001 || word_at(2) !== 16'h0001) begin
      $display("FAIL bp_record got=%0d:%h,%h,%h exp=3:8001,0001,0001",
               fifo_q.size(), word_at(0), word_at(1), word_at(2)); bad++;
    end
    total++;
    if (done_cyc - start_cyc != 414) begin
      $display("FAIL bp_latency got=%0d exp=414", done_cyc - start_cyc); bad++;
    end
    total++;
    trig_mode = 0;
  endtask

  task automatic test_ignored_start();
    clear_obs();
    start_test(10'h0F0, 16'd2);
    repeat (300) @(negedge Clk);
    start_test(10'h3AA, 16'd7);
    wait_done(700, "ignored");
    if (fifo_q.size() != 3 || word_at(0) !== 16'h80F0 || word_at(1) !== 16'h0002 || word_at(2) !== 16'h0000) begin
      $display("FAIL ignored_record got=%0d:%h,%h,%h exp=3:80f0,0002,0000",
               fifo_q.size(), word_at(0), word_at(1), word_at(2)); bad++;
    end
    total++;
    if (done_cyc - start_cyc != 804) begin
      $display("FAIL ignored_latency got=%0d exp=804", done_cyc - start_cyc); bad++;
    end
    total++;
  endtask

  task automatic test_mid_reset();
    int dc0;
    clear_obs();
    start_test(10'h111, 16'd3);
    repeat (600) @(negedge Clk);
    dc0 = done_cnt;
    reset_n = 1'b0;
    #1;
    if ({CTest_Pulse, SCurve_Data_fifo_wr_en, Single_Test_Done, Busy} !== 4'b0000 ||
        SCurve_Data_fifo_dout !== 16'h0000) begin
      $display("FAIL midreset_outputs ctrl=%b dout=%h exp=0000/0000",
               {CTest_Pulse, SCurve_Data_fifo_wr_en, Single_Test_Done, Busy},
               SCurve_Data_fifo_dout); bad++;
    end
    total++;
    repeat (3) @(negedge Clk);
    reset_n = 1'b1;
    repeat (1300) @(negedge Clk);
    if (done_cnt != dc0 || fifo_q.size() != 0 || Busy !== 1'b0) begin
      $display("FAIL midreset_quiet dones=%0d writes=%0d busy=%b exp=0/0/0",
               done_cnt - dc0, fifo_q.size(), Busy); bad++;
    end
    total++;
    clear_obs();
    trig_mode = 1; trig_dly = 5;
    start_test(10'h2A5, 16'd1);
    wait_done(600, "rerun");
    if (fifo_q.size() != 3 || word_at(0) !== 16'h82A5 || word_at(1) !== 16'h0001 || word_at(2) !== 16'h0001) begin
      $display("FAIL rerun_record got=%0d:%h,%h,%h exp=3:82a5,0001,0001",
               fifo_q.size(), word_at(0), word_at(1), word_at(2)); bad++;
    end
    total++;
    if (done_cyc - start_cyc != 404) begin
      $display("FAIL rerun_latency got=%0d exp=404", done_cyc - start_cyc); bad++;
    end
    total++;
    trig_mode = 0;
  endtask

  // Started on the first cycle after the previous Done.
  task automatic test_back_to_back_zero();
    clear_obs();
    start_test(10'h3FF, 16'd0);
    wait_done(20, "zero");
    if (fifo_q.size() != 3 || word_at(0) !== 16'h83FF || word_at(1) !== 16'h0000 || word_at(2) !== 16'h0000) begin
      $display("FAIL zero_record got=%0d:%h,%h,%h exp=3:83ff,0000,0000",
               fifo_q.size(), word_at(0), word_at(1), word_at(2)); bad++;
    end
    total++;
    if (done_cyc - start_cyc != 4) begin
      $display("FAIL zero_latency got=%0d exp=4", done_cyc - start_cyc); bad++;
    end
    total++;
    if (ctest_rises != 0) begin
      $display("FAIL zero_ctest_count got=%0d exp=0", ctest_rises); bad++;
    end
    total++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_late_trigger();
    test_multi_edge();
    test_back_pressure();
    test_ignored_start();
    test_mid_reset();
    test_back_to_back_zero();
    repeat (5) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
